// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter and its
// round-robin helper: FSM state encoding, byte width, requester limits.
package uart_pkg;

    localparam int BYTE_W      = 8;
    localparam int NUM_REQ_MIN = 2;
    localparam int NUM_REQ_MAX = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past ptr_i and
// wraps modulo N; the first active request wins.
//   req_i : request vector          ptr_i : last winner
//   gnt_o : one-hot grant           idx_o : binary index of the winner
//   any_o : at least one request is active
module rr_arbiter
    import uart_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    if (N < NUM_REQ_MIN || N > NUM_REQ_MAX) begin : g_bad_n
        $error("rr_arbiter: N out of range");
    end

    logic [IW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr_i) + k) % N);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte producers with
// round-robin arbitration per byte. Optional macro UART_ARB_LOCK_EN adds
// req_last so a granted requester keeps ownership until its last byte.
//   clock/reset_n             : clock, async active-low reset
//   req_valid/req_data/req_ready : per-requester byte handshake
//   req_last (lock build)     : marks the final byte of an owned burst
//   tx_send/tx_data/tx_complete  : transmitter handshake (complete=1 idle)
//   grant_id/busy/err_timeout : status
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int ACK_TIMEOUT = 15,
    localparam int IW          = $clog2(NUM_REQ),
    localparam int CW          = $clog2(ACK_TIMEOUT + 1)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        req_last,
`endif
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_send,
    output logic [BYTE_W-1:0]         tx_data,
    input  logic                      tx_complete,
    output logic [IW-1:0]             grant_id,
    output logic                      busy,
    output logic                      err_timeout
);

    if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX) begin : g_bad_req
        $error("uart_tx_arbiter: NUM_REQ out of range");
    end
    if (ACK_TIMEOUT < 1) begin : g_bad_tmo
        $error("uart_tx_arbiter: ACK_TIMEOUT must be >= 1");
    end

    localparam logic [CW-1:0] TMO     = CW'(ACK_TIMEOUT);
    localparam logic [IW-1:0] PTR_RST = IW'(NUM_REQ - 1);

    arb_state_e           state_q;
    logic [IW-1:0]        ptr_q;
    logic [CW-1:0]        cnt_q;
    logic [NUM_REQ-1:0]   req_ready_q;
    logic                 tx_send_q;
    logic [BYTE_W-1:0]    tx_data_q;
    logic [IW-1:0]        grant_q;
    logic                 busy_q;
    logic                 err_q;

    logic [NUM_REQ-1:0]   req_eff;
    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IW-1:0]        arb_idx;
    logic                 arb_any;
    logic [BYTE_W-1:0]    req_bytes [NUM_REQ];
    logic [BYTE_W-1:0]    win_byte;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_bytes[i] = req_data[BYTE_W*i +: BYTE_W];
        end
    end

    assign win_byte = req_bytes[arb_idx];

`ifdef UART_ARB_LOCK_EN
    logic lock_q;

    // While a burst is owned only the owner (last grant) may be selected;
    // if it is not requesting, nothing is granted.
    always_comb begin
        req_eff = req_valid;
        if (lock_q) begin
            req_eff = req_valid & (NUM_REQ'(1) << grant_q);
        end
    end
`else
    always_comb begin
        req_eff = req_valid;
    end
`endif

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .req_i (req_eff),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= PTR_RST;
            cnt_q       <= '0;
            req_ready_q <= '0;
            tx_send_q   <= 1'b0;
            tx_data_q   <= '0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            lock_q      <= 1'b0;
`endif
        end else begin
            req_ready_q <= '0;
            tx_send_q   <= 1'b0;
            err_q       <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // A low tx_complete means a frame is still on the wire
                    // (e.g. after a mid-frame reset): hold off.
                    if (arb_any && tx_complete) begin
                        req_ready_q <= arb_gnt;
                        tx_data_q   <= win_byte;
                        grant_q     <= arb_idx;
                        busy_q      <= 1'b1;
                        state_q     <= ISSUE;
`ifdef UART_ARB_LOCK_EN
                        if (req_last[arb_idx]) begin
                            lock_q <= 1'b0;
                            ptr_q  <= arb_idx;
                        end else begin
                            lock_q <= 1'b1;
                        end
`else
                        ptr_q       <= arb_idx;
`endif
                    end
                end
                ISSUE: begin
                    tx_send_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= WAIT_START;
                end
                WAIT_START: begin
                    if (!tx_complete) begin
                        state_q <= WAIT_DONE;
                    end else if (cnt_q == TMO) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    // Frame length depends on baud, so no timeout here.
                    if (tx_complete) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign tx_send     = tx_send_q;
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a list-level round-robin model
// predicts grant order; a monitor pops and compares on every grant.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ACK_TIMEOUT = 15;
    localparam int IW = $clog2(NUM_REQ);
    localparam int MAXB = 4;
`ifdef UART_ARB_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    logic                   clk;
    logic                   rst_n;
    logic [NUM_REQ-1:0]     req_valid;
    logic [8*NUM_REQ-1:0]   req_data;
`ifdef UART_ARB_LOCK_EN
    logic [NUM_REQ-1:0]     req_last;
`endif
    logic [NUM_REQ-1:0]     req_ready;
    logic                   tx_send;
    logic [7:0]             tx_data;
    logic                   tx_complete;
    logic [IW-1:0]          grant_id;
    logic                   busy;
    logic                   err_timeout;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int mdl_ptr = NUM_REQ - 1;
    int reset_gen = 0;
    int err_cnt = 0;
    int send_cyc = 0;
    int tx_delay = 10;
    bit tie_high = 1'b0;
    bit prev_ready = 1'b0;
    logic [7:0] pend_byte = 8'h00;

    exp_t exp_q[$];

    logic [7:0] src_mem [NUM_REQ][MAXB];
    bit         src_last[NUM_REQ][MAXB];
    int         src_cnt [NUM_REQ];
    int         src_rd  [NUM_REQ];

    uart_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clock       (clk),
        .reset_n     (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
`ifdef UART_ARB_LOCK_EN
        .req_last    (req_last),
`endif
        .req_ready   (req_ready),
        .tx_send     (tx_send),
        .tx_data     (tx_data),
        .tx_complete (tx_complete),
        .grant_id    (grant_id),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected service order from the round-robin rule applied to the
    // whole list of queued bytes; in the lock build an owner drains its
    // bytes up to and including one flagged last.
    task automatic predict(output int nbytes);
        int  rd[NUM_REQ];
        int  j;
        bit  found;
        bit  lst;
        exp_t e;
        nbytes = 0;
        for (int i = 0; i < NUM_REQ; i++) rd[i] = 0;
        forever begin
            found = 1'b0;
            j = 0;
            for (int k = 1; k <= NUM_REQ; k++) begin
                j = (mdl_ptr + k) % NUM_REQ;
                if (rd[j] < src_cnt[j]) begin
                    found = 1'b1;
                    break;
                end
            end
            if (!found) break;
            do begin
                e.idx  = j;
                e.data = src_mem[j][rd[j]];
                lst    = src_last[j][rd[j]];
                rd[j]++;
                exp_q.push_back(e);
                nbytes++;
            end while (LOCK && !lst && rd[j] < src_cnt[j]);
            mdl_ptr = j;
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < NUM_REQ; i++) begin
            src_cnt[i] = 0;
            src_rd[i]  = 0;
        end
    endtask

    task automatic rand_src(input int maxb);
        bit any = 1'b0;
        clear_src();
        while (!any) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                src_cnt[i] = ($urandom_range(0, 1) == 1) ?
                             int'($urandom_range(1, maxb)) : 0;
                if (src_cnt[i] > 0) any = 1'b1;
                for (int b = 0; b < MAXB; b++) begin
                    src_mem[i][b]  = 8'($urandom);
                    src_last[i][b] = (b == src_cnt[i] - 1) ? 1'b1 :
                                     1'($urandom_range(0, 1));
                end
            end
        end
    endtask

    task automatic start_phase(input bit chk_lat, output int nb);
        predict(nb);
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) begin
            src_rd[i] = 0;
            if (src_cnt[i] > 0) begin
                req_data[8*i +: 8] = src_mem[i][0];
`ifdef UART_ARB_LOCK_EN
                req_last[i] = src_last[i][0];
`endif
                req_valid[i] = 1'b1;
            end
        end
        if (chk_lat) begin
            @(negedge clk);
            chk("req_to_ready", 32'(req_ready != '0), 1);
        end
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (!(exp_q.size() == 0 && !busy && tx_complete &&
                 req_valid == '0)) begin
            @(negedge clk);
            n++;
            if (n > bound) begin
                total++;
                bad++;
                $display("FAIL wait_done: queue=%0d busy=%0b after %0d",
                         exp_q.size(), busy, n);
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        reset_gen++;
        mdl_ptr = NUM_REQ - 1;
        clear_src();
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Requesters: advance to the next byte on req_ready, else drop valid.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i] && src_rd[i] < src_cnt[i]) begin
                src_rd[i]++;
                if (src_rd[i] < src_cnt[i]) begin
                    req_data[8*i +: 8] = src_mem[i][src_rd[i]];
`ifdef UART_ARB_LOCK_EN
                    req_last[i] = src_last[i][src_rd[i]];
`endif
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Transmitter model: complete falls one cycle after send, rises
    // tx_delay cycles later; ignores send entirely when tie_high is set.
    initial forever begin
        int g;
        @(negedge clk);
        if (tx_send && !tie_high) begin
            g = reset_gen;
            @(negedge clk);
            tx_complete = 1'b0;
            repeat (tx_delay) @(negedge clk);
            if (g == reset_gen) chk("busy_before_done", 32'(busy), 1);
            tx_complete = 1'b1;
            @(negedge clk);
            if (g == reset_gen) chk("busy_after_done", 32'(busy), 0);
        end
    end

    // Monitor / scoreboard.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n) begin
            if (req_ready != '0) begin
                chk("ready_onehot", $countones(req_ready), 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", 32'(req_ready), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant_vec", 32'(req_ready), 32'(1) << e.idx);
                    chk("grant_id", 32'(grant_id), 32'(e.idx));
                    pend_byte = e.data;
                end
            end
            if (tx_send) begin
                chk("send_after_ready", 32'(prev_ready), 1);
                chk("tx_data", 32'(tx_data), 32'(pend_byte));
                chk("busy_in_send", 32'(busy), 1);
                send_cyc = cyc;
            end
            if (err_timeout) begin
                chk("err_expected", 32'(tie_high), 1);
                chk("err_latency", 32'(cyc - send_cyc), ACK_TIMEOUT + 1);
                err_cnt++;
            end
            prev_ready = (req_ready != '0);
        end
    end

    initial begin
        int nb;
        int e0;
        int n;
        rst_n = 1'b0;
        tx_complete = 1'b0;
        req_valid = '0;
        req_data = '0;
`ifdef UART_ARB_LOCK_EN
        req_last = '0;
`endif
        clear_src();
        repeat (2) @(negedge clk);
        chk("reset_outputs", {req_ready, tx_send, tx_data, grant_id,
                              busy, err_timeout}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Request while the transmitter is still busy at startup.
        src_cnt[0] = 1;
        src_mem[0][0] = 8'h55;
        src_last[0][0] = 1'b1;
        start_phase(1'b0, nb);
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            chk("no_grant_tx_busy", 32'(req_ready), 0);
        end
        tx_complete = 1'b1;
        @(negedge clk);
        chk("grant_after_complete", 32'(req_ready), 1);
        wait_done(200);

        // Single requester 0 again: it must win with the pointer on it.
        clear_src();
        src_cnt[0] = 1;
        src_mem[0][0] = 8'h55;
        src_last[0][0] = 1'b1;
        start_phase(1'b1, nb);
        wait_done(200);

        // All four requesting from reset pointer: order 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            src_cnt[i] = 1;
            src_mem[i][0] = 8'hA0 + 8'(i);
            src_last[i][0] = 1'b1;
        end
        src_cnt[0] = 2;
        src_mem[0][1] = 8'hA4;
        src_last[0][1] = 1'b1;
        start_phase(1'b1, nb);
        wait_done(500);

        // Randomised bursts.
        for (int p = 0; p < 10; p++) begin
            tx_delay = int'($urandom_range(2, 12));
            rand_src(3);
            start_phase(1'b1, nb);
            wait_done(2000);
        end

        // Transmitter never drops complete: each byte times out.
        tie_high = 1'b1;
        rand_src(1);
        e0 = err_cnt;
        start_phase(1'b1, nb);
        wait_done(1000);
        chk("timeout_count", 32'(err_cnt - e0), 32'(nb));
        tie_high = 1'b0;

        // Reset in the middle of a frame.
        tx_delay = 20;
        clear_src();
        src_cnt[1] = 1;
        src_mem[1][0] = 8'h3C;
        src_last[1][0] = 1'b1;
        start_phase(1'b1, nb);
        n = 0;
        while (!(busy && !tx_complete) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reached_wait_done", 32'(busy && !tx_complete), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        reset_gen++;
        #1;
        chk("reset_midframe", {req_ready, tx_send, tx_data, grant_id,
                               busy, err_timeout}, 0);
        mdl_ptr = NUM_REQ - 1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_src();
        src_cnt[2] = 1;
        src_mem[2][0] = 8'hC2;
        src_last[2][0] = 1'b1;
        start_phase(1'b0, nb);
        n = 0;
        forever begin
            @(posedge clk);
            if (tx_complete) break;
            @(negedge clk);
            chk("no_send_midframe", {req_ready, tx_send}, 0);
            n++;
            if (n > 60) begin
                total++;
                bad++;
                $display("FAIL midframe_wait: complete never rose");
                break;
            end
        end
        wait_done(500);

`ifdef UART_ARB_LOCK_EN
        // Requester 1 owns a 3-byte burst while requester 2 waits.
        tx_delay = 6;
        do_reset();
        src_cnt[1] = 3;
        src_mem[1][0] = 8'h11;
        src_mem[1][1] = 8'h12;
        src_mem[1][2] = 8'h13;
        src_last[1][0] = 1'b0;
        src_last[1][1] = 1'b0;
        src_last[1][2] = 1'b1;
        src_cnt[2] = 1;
        src_mem[2][0] = 8'h21;
        src_last[2][0] = 1'b1;
        start_phase(1'b1, nb);
        wait_done(500);
`endif

        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
